// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access pipeline stage. It takes one executed instruction
//             from EX, runs one data-bus transaction for loads and stores
//             (byte-lane steering, sign/zero extension, alignment check) and
//             presents the write-back data to WB.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               resetn_i,
  // EX side
  input  logic               valid_i,
  output logic               notify_o,
  input  logic [BITSIZE-1:0] pc_i,
  input  logic [BITSIZE-1:0] instr_i,
  input  logic [BITSIZE-1:0] result_i,
  input  logic [BITSIZE-1:0] rs2_i,
  // WB side
  input  logic               notify_i,
  output logic               valid_o,
  output logic [BITSIZE-1:0] pc_o,
  output logic [BITSIZE-1:0] instr_o,
  output logic [BITSIZE-1:0] wb_data_o,
  output logic               fault_o,
  // data bus
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [BITSIZE-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [BITSIZE-1:0] dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [BITSIZE-1:0] dmem_rdata_i
);

  // Only a 32-bit datapath is supported; stop elaboration otherwise.
  if (BITSIZE != 32) begin : g_bitsize_check
    $error("mem_stage: only BITSIZE = 32 is supported");
  end

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  state_t               w_cap_state;

  logic                 r_notify;
  logic                 r_fault;
  logic                 r_we;
  logic [3:0]           r_be;
  logic [BITSIZE-1:0]   r_pc;
  logic [BITSIZE-1:0]   r_instr;
  logic [BITSIZE-1:0]   r_addr;
  logic [BITSIZE-1:0]   r_wdata;
  logic [BITSIZE-1:0]   r_wb;
  logic [2:0]           r_f3;
  logic                 r_is_store;

  logic                 w_cap;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_is_mem;
  logic [2:0]           w_f3;
  logic [1:0]           w_a;
  logic                 w_bad_width;
  logic                 w_misalign;
  logic                 w_fault;
  logic [3:0]           w_cap_be;
  logic [BITSIZE-1:0]   w_cap_wdata;
  logic                 w_resp;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [BITSIZE-1:0]   w_load_data;

  // The notify_o guard keeps EX from being captured twice while it still
  // sees the previous pulse; capture is only possible with the output free.
  assign w_cap = valid_i && !r_notify &&
                 ((r_state == S_EMPTY) || ((r_state == S_FULL) && notify_i));

  // Decode, fault check, byte enables and store-data replication at capture.
  always_comb begin
    w_is_load   = (instr_i[6:0] == C_OP_LOAD);
    w_is_store  = (instr_i[6:0] == C_OP_STORE);
    w_is_mem    = w_is_load || w_is_store;
    w_f3        = instr_i[14:12];
    w_a         = result_i[1:0];
    w_bad_width = (w_is_load && ((w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7))) ||
                  (w_is_store && (w_f3 > 3'd2));
    w_misalign  = ((w_f3[1:0] == 2'b01) && w_a[0]) ||
                  ((w_f3[1:0] == 2'b10) && (w_a != 2'b00));
    w_fault     = w_is_mem && (w_bad_width || w_misalign);
    case (w_f3[1:0])
      2'b00:   w_cap_be = 4'b0001 << w_a;
      2'b01:   w_cap_be = 4'b0011 << w_a;
      default: w_cap_be = 4'b1111;
    endcase
    case (w_f3[1:0])
      2'b00:   w_cap_wdata = {4{rs2_i[7:0]}};
      2'b01:   w_cap_wdata = {2{rs2_i[15:0]}};
      default: w_cap_wdata = rs2_i;
    endcase
    w_cap_state = (w_is_mem && !w_fault) ? S_REQ : S_FULL;
  end

  // Lane select and sign/zero extension of the returned read word.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_f3)
      3'd0:    w_load_data = {{(BITSIZE-8){w_byte[7]}}, w_byte};
      3'd1:    w_load_data = {{(BITSIZE-16){w_half[15]}}, w_half};
      3'd4:    w_load_data = {{(BITSIZE-8){1'b0}}, w_byte};
      3'd5:    w_load_data = {{(BITSIZE-16){1'b0}}, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  // A response only counts in REQ together with the grant, or in WAIT.
  assign w_resp = ((r_state == S_REQ) && dmem_gnt_i && dmem_rvalid_i) ||
                  ((r_state == S_WAIT) && dmem_rvalid_i);

  // Next-state logic of the stage controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_cap) w_next = w_cap_state;
      S_REQ:   if (dmem_gnt_i) w_next = dmem_rvalid_i ? S_FULL : S_WAIT;
      S_WAIT:  if (dmem_rvalid_i) w_next = S_FULL;
      S_FULL:  if (notify_i) w_next = w_cap ? w_cap_state : S_EMPTY;
    endcase
  end

  // State and control flops; reset abandons any open bus transaction.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state  <= S_EMPTY;
      r_notify <= 1'b0;
      r_fault  <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= 4'b0000;
    end else begin
      r_state  <= w_next;
      r_notify <= w_cap;
      if (w_cap) begin
        r_fault <= w_fault;
        r_we    <= w_is_store && !w_fault;
        r_be    <= (w_is_mem && !w_fault) ? w_cap_be : 4'b0000;
      end
    end
  end

  // Datapath flops; their reset value is irrelevant.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_pc       <= pc_i;
      r_instr    <= instr_i;
      r_addr     <= result_i;
      r_f3       <= w_f3;
      r_is_store <= w_is_store;
      r_wdata    <= w_cap_wdata;
      r_wb       <= (w_is_mem || w_fault) ? '0 : result_i;
    end else if (w_resp) begin
      r_wb       <= r_is_store ? '0 : w_load_data;
    end
  end

  assign notify_o     = r_notify;
  assign valid_o      = (r_state == S_FULL);
  assign fault_o      = r_fault;
  assign pc_o         = r_pc;
  assign instr_o      = r_instr;
  assign wb_data_o    = r_wb;
  assign dmem_req_o   = (r_state == S_REQ);
  assign dmem_we_o    = r_we;
  assign dmem_be_o    = r_be;
  assign dmem_addr_o  = {r_addr[BITSIZE-1:2], 2'b00};
  assign dmem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage with a scoreboard of
//             expected write-back entries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        resetn_i;
  logic        valid_i;
  logic        notify_o;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [31:0] result_i;
  logic [31:0] rs2_i;
  logic        notify_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] wb_data_o;
  logic        fault_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wb;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mem_stage #(.BITSIZE(32)) dut (
    .clk(clk), .resetn_i(resetn_i),
    .valid_i(valid_i), .notify_o(notify_o),
    .pc_i(pc_i), .instr_i(instr_i), .result_i(result_i), .rs2_i(rs2_i),
    .notify_i(notify_i), .valid_o(valid_o),
    .pc_o(pc_o), .instr_o(instr_o), .wb_data_o(wb_data_o), .fault_o(fault_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd1, op};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one EX entry, record its expected result, wait for the capture pulse.
  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] res,
                      input logic [31:0] rs2, input logic [31:0] wb, input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.wb = wb; e.fault = fault;
    exp_q.push_back(e);
    pc_i = pc; instr_i = instr; result_i = res; rs2_i = rs2; valid_i = 1'b1;
    tick;
    for (int i = 0; i < 20 && !notify_o; i++) tick;
    chk("capture_notify", {31'd0, notify_o}, 32'd1);
    valid_i = 1'b0;
  endtask

  // Compare the presented entry against the scoreboard head.
  task automatic compare_head;
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed empty expected entry");
    end else begin
      e = exp_q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("instr_o", instr_o, e.instr);
      chk("wb_data_o", wb_data_o, e.wb);
      chk("fault_o", {31'd0, fault_o}, {31'd0, e.fault});
    end
  endtask

  task automatic retire;
    for (int i = 0; i < 20 && !valid_o; i++) tick;
    chk("retire_valid", {31'd0, valid_o}, 32'd1);
    compare_head;
    notify_i = 1'b1;
    tick;
    notify_i = 1'b0;
  endtask

  // Load with grant in the request cycle and read data two cycles later.
  task automatic mem_load(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] wb);
    send(pc, mk(f3, OP_LOAD), addr, 32'h0, wb, 1'b0);
    chk("ld_req", {31'd0, dmem_req_o}, 32'd1);
    chk("ld_addr", dmem_addr_o, {addr[31:2], 2'b00});
    chk("ld_be", {28'd0, dmem_be_o}, {28'd0, be});
    chk("ld_we", {31'd0, dmem_we_o}, 32'd0);
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    chk("ld_req_drop", {31'd0, dmem_req_o}, 32'd0);
    tick;
    chk("ld_wait_valid", {31'd0, valid_o}, 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    tick;
    dmem_rvalid_i = 1'b0;
    retire;
  endtask

  initial begin
    resetn_i = 1'b0; valid_i = 1'b0; notify_i = 1'b0;
    pc_i = '0; instr_i = '0; result_i = '0; rs2_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_notify_o", {31'd0, notify_o}, 32'd0);
    chk("rst_fault_o", {31'd0, fault_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    resetn_i = 1'b1;
    tick;

    // Non-memory pass-through.
    send(32'h1000, mk(3'd0, OP_ALU), 32'h1234, 32'h0, 32'h1234, 1'b0);
    chk("alu_valid_latency", {31'd0, valid_o}, 32'd1);
    chk("alu_no_req", {31'd0, dmem_req_o}, 32'd0);
    tick;
    chk("alu_notify_one_cycle", {31'd0, notify_o}, 32'd0);
    chk("alu_no_req2", {31'd0, dmem_req_o}, 32'd0);
    retire;
    chk("alu_empty_after", {31'd0, valid_o}, 32'd0);

    // Loads: sign/zero extension and lane selection.
    mem_load(32'h1004, 3'd0, 32'h103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    mem_load(32'h1008, 3'd4, 32'h103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    mem_load(32'h100C, 3'd1, 32'h102, 32'h8001_7F00, 4'b1100, 32'hFFFF_8001);
    mem_load(32'h1010, 3'd5, 32'h100, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC);
    mem_load(32'h1014, 3'd2, 32'h104, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // Halfword store, grant held back one cycle, then gnt+rvalid together.
    send(32'h1018, mk(3'd1, OP_STORE), 32'h202, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("sh_req", {31'd0, dmem_req_o}, 32'd1);
    chk("sh_we", {31'd0, dmem_we_o}, 32'd1);
    chk("sh_be", {28'd0, dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
    chk("sh_addr", dmem_addr_o, 32'h200);
    tick;
    chk("sh_req_held", {31'd0, dmem_req_o}, 32'd1);
    chk("sh_no_valid", {31'd0, valid_o}, 32'd0);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("sh_req_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("sh_valid", {31'd0, valid_o}, 32'd1);
    retire;

    // Byte store replicates the low byte.
    send(32'h101C, mk(3'd0, OP_STORE), 32'h301, 32'h1122_33A5, 32'h0, 1'b0);
    chk("sb_be", {28'd0, dmem_be_o}, 32'h2);
    chk("sb_wdata", dmem_wdata_o, 32'hA5A5_A5A5);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    retire;

    // Misaligned and illegal-width accesses fault without a bus request.
    send(32'h1020, mk(3'd2, OP_LOAD), 32'h105, 32'h0, 32'h0, 1'b1);
    chk("mis_no_req", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_valid", {31'd0, valid_o}, 32'd1);
    retire;
    send(32'h1024, mk(3'd1, OP_STORE), 32'h107, 32'h0, 32'h0, 1'b1);
    chk("mis_sh_no_req", {31'd0, dmem_req_o}, 32'd0);
    retire;
    send(32'h1028, mk(3'd6, OP_LOAD), 32'h100, 32'h0, 32'h0, 1'b1);
    chk("ill_ld_no_req", {31'd0, dmem_req_o}, 32'd0);
    retire;
    send(32'h102C, mk(3'd3, OP_STORE), 32'h100, 32'h0, 32'h0, 1'b1);
    chk("ill_st_no_req", {31'd0, dmem_req_o}, 32'd0);
    retire;

    // Back-pressure: hold WB off while EX keeps offering a new entry.
    send(32'h2000, mk(3'd0, OP_ALU), 32'h55, 32'h0, 32'h55, 1'b0);
    pc_i = 32'h2004; instr_i = mk(3'd7, OP_ALU); result_i = 32'h66; valid_i = 1'b1;
    begin
      exp_t e;
      e.pc = 32'h2004; e.instr = mk(3'd7, OP_ALU); e.wb = 32'h66; e.fault = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_pc_hold", pc_o, 32'h2000);
      chk("bp_wb_hold", wb_data_o, 32'h55);
      chk("bp_no_capture", {31'd0, notify_o}, 32'd0);
    end
    compare_head;
    notify_i = 1'b1;
    tick;
    notify_i = 1'b0; valid_i = 1'b0;
    chk("bp_capture_notify", {31'd0, notify_o}, 32'd1);
    chk("bp_new_pc", pc_o, 32'h2004);
    retire;

    // Reset while requesting drops the request without a clock edge.
    send(32'h3000, mk(3'd2, OP_LOAD), 32'h300, 32'h0, 32'h0, 1'b0);
    chk("rreq_req", {31'd0, dmem_req_o}, 32'd1);
    #3 resetn_i = 1'b0;
    #1;
    chk("rreq_async_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rreq_async_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #3 resetn_i = 1'b1;
    tick;
    exp_q.delete();

    // Reset while waiting for read data; the late rvalid must be ignored.
    send(32'h3004, mk(3'd2, OP_LOAD), 32'h300, 32'h0, 32'h0, 1'b0);
    dmem_gnt_i = 1'b1;
    tick;
    dmem_gnt_i = 1'b0;
    #3 resetn_i = 1'b0;
    #1;
    chk("rwait_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rwait_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #3 resetn_i = 1'b1;
    tick;
    exp_q.delete();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    tick;
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid_valid", {31'd0, valid_o}, 32'd0);
    chk("late_rvalid_req", {31'd0, dmem_req_o}, 32'd0);
    notify_i = 1'b1;
    tick;
    notify_i = 1'b0;
    chk("stray_notify_valid", {31'd0, valid_o}, 32'd0);

    // Stage still works after the reset sequence.
    send(32'h4000, mk(3'd0, OP_ALU), 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b0);
    retire;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined core; sits directly downstream of the execute stage and upstream of write-back.
- Captures an executed instruction (pc, instr, ALU result, rs2 data) through the codebase valid/notify handshake.
- For loads and stores, performs one data-bus transaction with byte-lane steering, sign/zero extension and alignment checking.
- Presents write-back data to the next stage through the same valid/notify handshake.

Parameters:
- BITSIZE, 32, datapath width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- resetn_i  in  1  asynchronous active-low reset
- valid_i  in  1  EX output valid
- notify_o  out  1  one-cycle pulse: EX entry captured at the previous edge
- pc_i  in  32  pc of the EX instruction
- instr_i  in  32  EX instruction
- result_i  in  32  ALU result; this is the effective address for load/store
- rs2_i  in  32  store data
- notify_i  in  1  WB has captured the current output
- valid_o  out  1  output entry valid
- pc_o  out  32  registered pc
- instr_o  out  32  registered instruction
- wb_data_o  out  32  load data or pass-through result
- fault_o  out  1  misaligned or illegal-width access; qualified by valid_o
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address: {result[31:2], 2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  response or write acknowledge
- dmem_rdata_i  in  32  read word

Behaviour:
- Clock and reset: one clock `clk`. Reset `resetn_i` is asynchronous and active-low.
- Reset values: state = EMPTY; valid_o = notify_o = fault_o = dmem_req_o = dmem_we_o = 0; dmem_be_o = 0. Data registers are don't-care.
- Reset mid-transaction: abandons the transaction, drops dmem_req_o immediately, and ignores any late rvalid.
- States: EMPTY, REQ, WAIT, FULL.
- Capture condition: valid_i && !notify_o && (state == EMPTY || (state == FULL && notify_i)).
  - Latches pc, instr, result and rs2.
  - Sets notify_o = 1 for exactly the next cycle.
- !notify_o guard: prevents double-capture while EX is still reacting to the pulse.
- Decode at capture:
  - opcode 0000011 = load; 0100011 = store; anything else = non-memory.
  - funct3 = instr[14:12].
- Non-memory instruction: next state FULL; wb_data_o = result_i; fault_o = 0. Latency 1 cycle.
- Fault check at capture:
  - Fault = load funct3 in {3, 6, 7}, or store funct3 > 2.
  - Fault = halfword access with addr[0] = 1, or word access with addr[1:0] != 0.
  - On fault: go to FULL with fault_o = 1 and wb_data_o = 0. No bus request is issued.
- Load/store without fault: go to REQ.
  - dmem_req_o = 1 for the whole REQ state, with addr/we/be/wdata held stable.
- REQ: on dmem_gnt_i, go to WAIT and drop dmem_req_o. A gnt and rvalid arriving in the same cycle is legal; the stage goes straight to FULL.
- WAIT: on dmem_rvalid_i, go to FULL.
  - Load: wb_data_o = extracted data.
  - Store: wb_data_o = 0; the rvalid is the write acknowledge.
- Byte enables:
  - Byte access: be = 4'b0001 << addr[1:0].
  - Half access: be = 4'b0011 << addr[1:0].
  - Word access: be = 4'b1111.
- Store data: SB replicates rs2[7:0] to all 4 lanes; SH replicates rs2[15:0] to both halves; SW sends rs2 unchanged.
- Load extraction: lane select by addr[1:0].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: full word.
- FULL: valid_o = 1. On notify_i, the entry retires.
  - If a capture also occurs in that cycle, the next state follows from the new instruction.
  - Otherwise the next state is EMPTY.
- Stall behaviour: outputs hold stable while FULL && !notify_i. The stage does not capture while in REQ or WAIT.
- Throughput: 1 instruction per 2 cycles for non-memory instructions, because of the notify guard. Memory ops take 2 cycles plus bus latency.
- Protocol errors: notify_i when !valid_o, and dmem_rvalid_i outside WAIT/REQ, are both ignored.

Test Plan:
- Non-memory pass-through: ADD instr with result_i = 0x1234, valid_i held → notify_o pulses 1 cycle after capture; valid_o = 1 with wb_data_o = 0x1234 one cycle after capture; dmem_req_o stays 0.
- Load sign extension: LB at addr 0x103, dmem_rdata_i = 0x80FF_0000, gnt same cycle, rvalid after 2 cycles → dmem_addr_o = 0x100, be = 4'b1000, wb_data_o = 0xFFFF_FF80. The same access as LBU → wb_data_o = 0x0000_0080.
- Halfword store: SH at addr 0x202 with rs2 = 0xDEAD_BEEF → dmem_we_o = 1, be = 4'b1100, wdata = 0xBEEF_BEEF. valid_o rises only after rvalid; wb_data_o = 0.
- Misaligned access: LW at 0x105 → no dmem_req_o; FULL one cycle after capture with fault_o = 1, wb_data_o = 0.
- Back-pressure: hold notify_i = 0 for 5 cycles while FULL with valid_i = 1 → outputs stable, no capture. Assert notify_i → the new entry is captured on the same edge and notify_o pulses next cycle.
- Reset during WAIT: deassert resetn_i → dmem_req_o and valid_o go 0 asynchronously. After release, a late rvalid is ignored and the stage stays EMPTY.
